// File: rtl/dac_request_arbiter.sv
// Grants the single DAC sample stream to either the source or BIST driver, forwards the granted
// driver's requests with a minimum spacing, and keeps saturating underrun/drop counters.
module dac_request_arbiter #(
    parameter int unsigned MIN_GAP        = 6,
    parameter int unsigned SWITCH_HOLDOFF = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             capture_clk_i,
    input  logic             reset_i,
    input  logic             dac_open_i,
    input  logic             sel_bist_i,
    input  logic             src_request_i,
    input  logic             bist_request_i,
    input  logic             dac_underrun_i,
    output logic             dac_request_o,
    output logic             src_enable_o,
    output logic             bist_enable_o,
    output logic             active_bist_o,
    output logic             switching_o,
    output logic             request_dropped_o,
    output logic [CNT_W-1:0] underrun_count_o,
    output logic [CNT_W-1:0] drop_count_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic             active_bist_q, active_bist_d;
    logic [7:0]       holdoff_q, holdoff_d;
    logic [7:0]       gap_q, gap_d;
    logic             dac_request_q, dac_request_d;
    logic             dropped_q, dropped_d;
    logic [CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             granted_req;

    always_ff @(posedge capture_clk_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            active_bist_q  <= 1'b0;
            holdoff_q      <= '0;
            gap_q          <= '0;
            dac_request_q  <= 1'b0;
            dropped_q      <= 1'b0;
            underrun_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            active_bist_q  <= active_bist_d;
            holdoff_q      <= holdoff_d;
            gap_q          <= gap_d;
            dac_request_q  <= dac_request_d;
            dropped_q      <= dropped_d;
            underrun_cnt_q <= underrun_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        active_bist_d = active_bist_q;
        holdoff_d     = holdoff_q;
        unique case (state_q)
            StIdle: begin
                if (dac_open_i) begin
                    state_d       = StRun;
                    active_bist_d = sel_bist_i;
                end
            end
            StRun: begin
                if (!dac_open_i) begin
                    state_d = StIdle;
                end else if (sel_bist_i != active_bist_q) begin
                    state_d   = StDrain;
                    holdoff_d = 8'(SWITCH_HOLDOFF - 1);
                end
            end
            StDrain: begin
                if (!dac_open_i) begin
                    state_d = StIdle;
                end else if (holdoff_q == '0) begin
                    state_d       = StRun;
                    active_bist_d = sel_bist_i;
                end else begin
                    holdoff_d = holdoff_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Only the granted driver's request is seen; everything else is silently ignored.
    assign granted_req = active_bist_q ? bist_request_i : src_request_i;

    always_comb begin
        dac_request_d = 1'b0;
        dropped_d     = 1'b0;
        gap_d         = '0;
        if (state_q == StRun) begin
            gap_d = (gap_q != '0) ? gap_q - 8'd1 : '0;
            if (granted_req) begin
                if (gap_q == '0) begin
                    dac_request_d = 1'b1;
                    gap_d         = 8'(MIN_GAP - 1);
                end else begin
                    dropped_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        if (dac_underrun_i && (underrun_cnt_q != '1)) begin
            underrun_cnt_d = underrun_cnt_q + 1'b1;
        end
        if (dropped_q && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_comb begin
        src_enable_o  = 1'b0;
        bist_enable_o = 1'b0;
        switching_o   = 1'b0;
        unique case (state_q)
            StRun: begin
                src_enable_o  = !active_bist_q;
                bist_enable_o = active_bist_q;
            end
            StDrain: switching_o = 1'b1;
            default: ;
        endcase
    end

    assign active_bist_o     = active_bist_q;
    assign dac_request_o     = dac_request_q;
    assign request_dropped_o = dropped_q;
    assign underrun_count_o  = underrun_cnt_q;
    assign drop_count_o      = drop_cnt_q;

endmodule

// File: tb/tb_dac_request_arbiter.sv
// Directed bench for dac_request_arbiter: grant, forwarding, gap drops, switch holdoff,
// dac_open loss and counter saturation.
module tb_dac_request_arbiter;

    logic        clk = 1'b0;
    logic        reset, dac_open, sel_bist, src_request, bist_request, dac_underrun;
    logic        dac_request, src_enable, bist_enable, active_bist, switching, request_dropped;
    logic [15:0] underrun_count, drop_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dac_request_arbiter dut (
        .capture_clk_i    (clk),
        .reset_i          (reset),
        .dac_open_i       (dac_open),
        .sel_bist_i       (sel_bist),
        .src_request_i    (src_request),
        .bist_request_i   (bist_request),
        .dac_underrun_i   (dac_underrun),
        .dac_request_o    (dac_request),
        .src_enable_o     (src_enable),
        .bist_enable_o    (bist_enable),
        .active_bist_o    (active_bist),
        .switching_o      (switching),
        .request_dropped_o(request_dropped),
        .underrun_count_o (underrun_count),
        .drop_count_o     (drop_count)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_src();
        src_request = 1'b1;
        step();
        src_request = 1'b0;
    endtask

    task automatic pulse_bist();
        bist_request = 1'b1;
        step();
        bist_request = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dac_open = 1'b0; sel_bist = 1'b0;
        src_request = 1'b0; bist_request = 1'b0; dac_underrun = 1'b0;
        step(2);
        chk("rst_src_en", 32'(src_enable), 0);
        chk("rst_bist_en", 32'(bist_enable), 0);
        chk("rst_active", 32'(active_bist), 0);
        chk("rst_switching", 32'(switching), 0);
        chk("rst_dreq", 32'(dac_request), 0);
        chk("rst_ucnt", 32'(underrun_count), 0);
        chk("rst_dcnt", 32'(drop_count), 0);

        // 1: grant source
        reset = 1'b0; dac_open = 1'b1;
        step();
        chk("t1_src_en", 32'(src_enable), 1);
        chk("t1_bist_en", 32'(bist_enable), 0);
        chk("t1_active", 32'(active_bist), 0);

        // 2: well-spaced requests all forwarded
        for (int k = 0; k < 3; k++) begin
            pulse_src();
            chk("t2_dreq_hi", 32'(dac_request), 1);
            step();
            chk("t2_dreq_lo", 32'(dac_request), 0);
            step(8);
        end
        chk("t2_dcnt", 32'(drop_count), 0);

        // 3: request 3 cycles after an accepted one is dropped
        pulse_src();
        chk("t3_dreq0", 32'(dac_request), 1);
        step(2);
        pulse_src();
        chk("t3_dreq3", 32'(dac_request), 0);
        chk("t3_dropped", 32'(request_dropped), 1);
        step();
        chk("t3_dropped_lo", 32'(request_dropped), 0);
        chk("t3_dcnt", 32'(drop_count), 1);
        step(10);
        pulse_bist();
        chk("t3_inactive_dreq", 32'(dac_request), 0);
        chk("t3_inactive_drop", 32'(request_dropped), 0);

        // 4: switch to BIST with 16-cycle holdoff, source requests ignored
        sel_bist = 1'b1;
        step();
        src_request = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_switching", 32'(switching), 1);
            chk("t4_enables", 32'({src_enable, bist_enable}), 0);
            chk("t4_dreq", 32'(dac_request), 0);
            if (i < 15) step();
        end
        src_request = 1'b0;
        step();
        chk("t4_switch_done", 32'(switching), 0);
        chk("t4_bist_en", 32'(bist_enable), 1);
        chk("t4_src_en", 32'(src_enable), 0);
        chk("t4_active", 32'(active_bist), 1);
        chk("t4_dcnt", 32'(drop_count), 1);
        pulse_bist();
        chk("t4_first_bist_req", 32'(dac_request), 1);

        // 5: lose dac_open mid-RUN, then mid-DRAIN
        step(3);
        dac_open = 1'b0;
        step();
        chk("t5_run_idle_en", 32'({src_enable, bist_enable}), 0);
        chk("t5_run_idle_sw", 32'(switching), 0);
        dac_open = 1'b1;
        step();
        chk("t5_rerun_bist", 32'(bist_enable), 1);
        sel_bist = 1'b0;
        step();
        chk("t5_drain", 32'(switching), 1);
        step(4);
        dac_open = 1'b0;
        step();
        chk("t5_drain_idle_sw", 32'(switching), 0);
        chk("t5_drain_idle_en", 32'({src_enable, bist_enable}), 0);
        dac_open = 1'b1;
        step();
        chk("t5_rerun_src", 32'(src_enable), 1);
        chk("t5_rerun_active", 32'(active_bist), 0);

        // 6: underrun counter saturates, clears only on reset
        dac_underrun = 1'b1;
        step(100);
        chk("t6_ucnt100", 32'(underrun_count), 100);
        step(69900);
        chk("t6_ucnt_sat", 32'(underrun_count), 32'hFFFF);
        dac_underrun = 1'b0;
        step(3);
        chk("t6_ucnt_hold", 32'(underrun_count), 32'hFFFF);
        reset = 1'b1;
        step();
        chk("t6_ucnt_rst", 32'(underrun_count), 0);
        chk("t6_dcnt_rst", 32'(drop_count), 0);
        chk("t6_rst_en", 32'({src_enable, bist_enable}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
